// File: rtl/vigna_bus_mem.sv
// Dual-port simulation memory for a small RISC-V core: one instruction-fetch
// port and one data port. Each port has its own latency and its own
// IDLE/WAIT/RESP handshake FSM. A store to the host mailbox address does not
// touch memory. Instead it latches the stored word into tohost_data. Fetching
// the halt encoding sets a sticky halt flag.
//
// Ports:
//   clk, reset                      single clock, async active-high reset
//   i_valid/i_addr/i_ready/i_rdata  instruction fetch (read only)
//   d_valid/d_addr/d_wdata/d_wstrb  data access (wstrb == 0 means read)
//   d_ready/d_rdata                 data response
//   halt                            sticky, set when the halt word is fetched
//   tohost_valid/tohost_data        sticky mailbox flag and last mailbox word
//   i_count/d_count                 completed responses per port (wrapping)
module vigna_bus_mem #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned I_LAT       = 1,
  parameter int unsigned D_LAT       = 1,
  parameter logic [31:0] HALT_WORD   = 32'hFF800067,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        halt,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic [31:0] i_count,
  output logic [31:0] d_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] mem [Depth];

  // Instruction port
  state_e      i_state_q, i_state_d;
  logic [3:0]  i_cnt_q, i_cnt_d;
  logic [31:0] i_addr_q, i_addr_eff;
  logic        i_go;
  logic [ADDR_W-1:0] i_idx;

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_go      = 1'b0;
    unique case (i_state_q)
      StIdle: begin
        if (i_valid) begin
          if (I_LAT == 1) begin
            i_state_d = StResp;
            i_go      = 1'b1;
          end else begin
            i_state_d = StWait;
            i_cnt_d   = 4'(I_LAT - 1);
          end
        end
      end
      StWait: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (i_cnt_q == 4'd1) begin
          i_state_d = StResp;
          i_go      = 1'b1;
        end
      end
      StResp:  i_state_d = StIdle;
      default: i_state_d = StIdle;
    endcase
  end

  // With latency 1 the response edge is also the capture edge, so the live
  // address must be used instead of the (not yet loaded) captured one.
  assign i_addr_eff = (i_state_q == StIdle) ? i_addr : i_addr_q;
  assign i_idx      = i_addr_eff[ADDR_W+1:2];
  assign i_ready    = (i_state_q == StResp);

  logic unused_i_addr;
  assign unused_i_addr = ^{i_addr_eff[31:ADDR_W+2], i_addr_eff[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state_q <= StIdle;
      i_cnt_q   <= 4'd0;
      i_addr_q  <= 32'd0;
      i_rdata   <= 32'd0;
      halt      <= 1'b0;
      i_count   <= 32'd0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      if (i_state_q == StIdle && i_valid) i_addr_q <= i_addr;
      if (i_go) begin
        i_rdata <= mem[i_idx];
        if (mem[i_idx] == HALT_WORD) halt <= 1'b1;
      end
      if (i_state_q == StResp) i_count <= i_count + 32'd1;
    end
  end

  // Data port
  state_e      d_state_q, d_state_d;
  logic [3:0]  d_cnt_q, d_cnt_d;
  logic [31:0] d_addr_q, d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic [31:0] d_addr_eff, d_wdata_eff;
  logic [3:0]  d_wstrb_eff;
  logic        d_go, d_is_host, d_is_write;
  logic [ADDR_W-1:0] d_idx;

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_go      = 1'b0;
    unique case (d_state_q)
      StIdle: begin
        if (d_valid) begin
          if (D_LAT == 1) begin
            d_state_d = StResp;
            d_go      = 1'b1;
          end else begin
            d_state_d = StWait;
            d_cnt_d   = 4'(D_LAT - 1);
          end
        end
      end
      StWait: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q == 4'd1) begin
          d_state_d = StResp;
          d_go      = 1'b1;
        end
      end
      StResp:  d_state_d = StIdle;
      default: d_state_d = StIdle;
    endcase
  end

  assign d_addr_eff  = (d_state_q == StIdle) ? d_addr  : d_addr_q;
  assign d_wdata_eff = (d_state_q == StIdle) ? d_wdata : d_wdata_q;
  assign d_wstrb_eff = (d_state_q == StIdle) ? d_wstrb : d_wstrb_q;
  assign d_idx       = d_addr_eff[ADDR_W+1:2];
  assign d_is_host   = (d_addr_eff == TOHOST_ADDR);
  assign d_is_write  = |d_wstrb_eff;
  assign d_ready     = (d_state_q == StResp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state_q    <= StIdle;
      d_cnt_q      <= 4'd0;
      d_addr_q     <= 32'd0;
      d_wdata_q    <= 32'd0;
      d_wstrb_q    <= 4'd0;
      d_rdata      <= 32'd0;
      tohost_valid <= 1'b0;
      tohost_data  <= 32'd0;
      d_count      <= 32'd0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      if (d_state_q == StIdle && d_valid) begin
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
        d_wstrb_q <= d_wstrb;
      end
      if (d_go) begin
        d_rdata <= d_is_host ? tohost_data : mem[d_idx];
        if (d_is_host && d_is_write) begin
          tohost_valid <= 1'b1;
          tohost_data  <= d_wdata_eff;
        end
      end
      if (d_state_q == StResp) d_count <= d_count + 32'd1;
    end
  end

  // Storage is never reset; the reset gate keeps a same-edge D_LAT=1 accept
  // from writing while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && d_go && d_is_write && !d_is_host) begin
      for (int b = 0; b < 4; b++) begin
        if (d_wstrb_eff[b]) mem[d_idx][8*b +: 8] <= d_wdata_eff[8*b +: 8];
      end
    end
  end

endmodule
